mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter sharing one single-port unified memory between the instruction-fetch port (read-only) and the data-memory stage port (read/write) of the 5-stage MIPS pipeline. It serialises requests, drives a req/ack backend handshake and returns per-port stall and valid signals. The stalls feed the same freeze path as `hazard` (stalling IF and the pipeline registers). Data-stage requests have priority because they belong to the older instruction.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `ACK_TIMEOUT`, 255: cycles in a busy state with no `memAck` before `memErr` sets; 0 disables the check.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `ifReq` in 1: fetch request, held until `ifValid` or `ifKill`.
- `ifAddr` in ADDR_W: fetch address.
- `ifKill` in 1: branch/jump flush; cancels the pending or outstanding fetch.
- `ifRdata` out DATA_W: fetched instruction, registered.
- `ifValid` out 1: one-cycle pulse when the fetch completes.
- `ifStall` out 1: `ifReq & ~ifValid`, combinational.
- `dmReq` in 1: data request, held until `dmValid`.
- `dmWe` in 1: 1 = write.
- `dmAddr` in ADDR_W: data address.
- `dmWdata` in DATA_W: write data.
- `dmRdata` out DATA_W: load data, registered; holds its last value on writes.
- `dmValid` out 1: one-cycle completion pulse (reads and writes).
- `dmStall` out 1: `dmReq & ~dmValid`, combinational.
- `memReq` out 1: backend request.
- `memWe` out 1: backend write enable.
- `memAddr` out ADDR_W: backend address.
- `memWdata` out DATA_W: backend write data.
- `memAck` in 1: backend completion, single cycle.
- `memRdata` in DATA_W: read data, valid when `memAck`=1.
- `memErr` out 1: sticky timeout flag.

## Operation
- States: IDLE, DM_BUSY, IF_BUSY, IF_DISCARD.
- IDLE, all conditions sampled on the edge:
  - An eligible `dmReq` goes to DM_BUSY. `memReq`/`memWe`/`memAddr`/`memWdata` are loaded from the dm port.
  - Otherwise an eligible `ifReq` with `ifKill`=0 goes to IF_BUSY, with `memWe`=0.
  - Both eligible: dm wins.
- Eligibility mask: a port whose valid is high this cycle is not eligible this cycle. This prevents re-issue while the requester's pipeline register advances.
- DM_BUSY/IF_BUSY: `memReq` and all `mem*` outputs stay stable until `memAck`=1. On that edge:
  - `memReq`←0.
  - For reads, the port's rdata register ←`memRdata`.
  - The port's valid ←1 for one cycle.
  - State ←IDLE.
- `ifKill`=1 in IF_BUSY without `memAck` goes to IF_DISCARD. `memReq` stays high; the backend transaction is never abandoned.
- IF_DISCARD: on `memAck`, go to IDLE with no `ifValid` and `ifRdata` unchanged.
- `ifKill` and `memAck` in the same cycle in IF_BUSY: result discarded, no `ifValid`, go to IDLE.
- `ifKill` in IDLE masks `ifReq` that cycle. `ifKill` has no effect on dm transactions.
- Watchdog:
  - Counter clears on entry to any busy state and increments each busy cycle without `memAck`.
  - At count == `ACK_TIMEOUT`, `memErr`←1 (sticky until reset).
  - The transaction keeps waiting; the counter saturates.
- Reset values: state IDLE; `memReq`, `memWe`, `ifValid`, `dmValid`, `memErr` 0; `memAddr`, `memWdata`, `ifRdata`, `dmRdata` 0.
- Reset mid-transaction: `memReq` drops immediately and asynchronously. The backend is reset by the same signal.

## Timing
- Cycle 0: `dmReq` high in IDLE. Cycle 1: `memReq`=1. Earliest `memAck` is in cycle 1. Cycle 2: `dmValid`=1, arbiter back in IDLE.
- Minimum request-to-valid latency is 2 cycles. Generally it is 1 + (cycles `memReq` is high).
- The cycle `memReq` is low (the valid cycle) may issue the other port's request. A new request from the same port starts one cycle after its valid.
- Back-to-back throughput is one transaction per 2 cycles minimum.
- `memAck` is ignored in IDLE.
- `ifStall`/`dmStall` are the only combinational outputs.

## Structure
- Package `mem_arb_pkg`:
  - `arbState_t` enum {IDLE, DM_BUSY, IF_BUSY, IF_DISCARD}.
  - Owner constants `OWN_NONE`/`OWN_IF`/`OWN_DM`.
  - Default widths.
- One sub-module `ack_watchdog` holds the saturating timeout counter and the sticky `memErr`. Everything else is one FSM block plus output registers.

## Test plan
- dm read 0x40, `memAck` in cycle 1 with `memRdata`=0x1234ABCD → `dmValid` pulse in cycle 2, `dmRdata`=0x1234ABCD, `dmStall` high cycles 0–1.
- `ifReq`(0x100) and `dmReq`(write 0x200, 0xCAFE) together → write issued first. Fetch issued in the cycle `dmValid` is high; `ifValid` 2 cycles later when ack is immediate.
- Fetch 0x104 with 3-cycle ack delay, `ifKill` in cycle 2 → `memReq` held until ack, no `ifValid`, `ifRdata` unchanged, IDLE afterwards.
- `ifKill` coincident with `memAck` → no `ifValid`. A `dmReq` issued the next cycle is served normally.
- `ACK_TIMEOUT`=4, backend never acks → `memErr` rises after 4 busy cycles and stays; async `reset`=0 mid-wait clears `memReq` and `memErr` immediately.
- Requester holding `ifReq` through its `ifValid` cycle → exactly one backend transaction, no duplicate.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the unified-memory arbiter that sits
//   between the MIPS fetch stage, the data-memory stage and a single-port
//   backend memory.
//
//   Contents:
//     - default address/data widths and default ack timeout
//     - arbState_t : arbiter FSM state encoding
//     - OWN_*      : which requester currently owns the backend
//     - state_owner(): maps a state to its owning port
//     - is_busy()    : true while a backend transaction is outstanding
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF      = 32;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned ACK_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DM_BUSY    = 2'd1,
    IF_BUSY    = 2'd2,
    IF_DISCARD = 2'd3
  } arbState_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;

  // A discarded fetch still owns the backend: the transaction is never
  // abandoned, only its result is dropped.
  function automatic logic [1:0] state_owner(input arbState_t s);
    logic [1:0] own;
    own = OWN_NONE;
    case (s)
      DM_BUSY:    own = OWN_DM;
      IF_BUSY:    own = OWN_IF;
      IF_DISCARD: own = OWN_IF;
      default:    own = OWN_NONE;
    endcase
    return own;
  endfunction

  function automatic logic is_busy(input arbState_t s);
    return state_owner(s) != OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// ack_watchdog
//   Saturating counter of busy cycles without a backend acknowledge, plus the
//   sticky timeout flag. The flag sets on the edge where the count reaches
//   ACK_TIMEOUT, so it is visible after ACK_TIMEOUT unacknowledged busy cycles.
//   ACK_TIMEOUT = 0 disables the flag entirely.
//
//   Ports:
//     clk      in  : clock, rising edge
//     reset    in  : asynchronous, active-low
//     start_i  in  : a transaction is being issued this cycle (clears count)
//     busy_i   in  : a transaction is outstanding this cycle
//     ack_i    in  : backend acknowledge this cycle
//     err_o    out : sticky timeout flag (registered)
// -----------------------------------------------------------------------------
module ack_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic err_o
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);
  localparam logic TMO_EN = (ACK_TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             stalled;

  assign stalled = busy_i & ~ack_i & ~start_i;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (stalled && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Once saturated the count stays at CNT_MAX; the flag is sticky anyway.
    if (TMO_EN && stalled && (cnt_d == CNT_MAX)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port unified memory between the instruction-fetch port
//   (read-only) and the data-memory stage port (read/write). Requests are
//   serialised onto a req/ack backend; the data port wins ties because it
//   belongs to the older instruction.
//
//   Handshake summary (all ports):
//     A requester raises *Req with stable address/data and holds it until the
//     matching *Valid pulse (the fetch port may also give up via ifKill).
//     *Valid is a one-cycle registered pulse; during that cycle the port is
//     not eligible, so a request still held while the pipeline register
//     advances is not issued twice. The backend sees memReq with stable
//     memWe/memAddr/memWdata until a single-cycle memAck; memRdata is sampled
//     on that edge. memAck outside a transaction is ignored.
//
//   Ports:
//     clk, reset            clock / asynchronous active-low reset
//     ifReq/ifAddr/ifKill   fetch request, address, flush
//     ifRdata/ifValid       fetched word (registered) and completion pulse
//     ifStall               ifReq & ~ifValid (combinational)
//     dmReq/dmWe/dmAddr/dmWdata  data request
//     dmRdata/dmValid       load data (registered) and completion pulse
//     dmStall               dmReq & ~dmValid (combinational)
//     memReq/memWe/memAddr/memWdata  backend request (registered)
//     memAck/memRdata       backend completion and read data
//     memErr                sticky acknowledge-timeout flag
//     dbgState              current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  input  logic              ifKill,
  output logic [DATA_W-1:0] ifRdata,
  output logic              ifValid,
  output logic              ifStall,
  // data port
  input  logic              dmReq,
  input  logic              dmWe,
  input  logic [ADDR_W-1:0] dmAddr,
  input  logic [DATA_W-1:0] dmWdata,
  output logic [DATA_W-1:0] dmRdata,
  output logic              dmValid,
  output logic              dmStall,
  // backend
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRdata,
  output logic              memErr,
  // observation
  output arbState_t         dbgState
);

  arbState_t         state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              dm_valid_q;

  // A port is masked in the cycle its valid pulse is out: its request line is
  // still up for the instruction that is just completing.
  logic dm_elig;
  logic if_elig;
  logic issue;
  logic busy;

  assign dm_elig = dmReq & ~dm_valid_q;
  assign if_elig = ifReq & ~if_valid_q & ~ifKill;
  assign issue   = (state_q == IDLE) & (dm_elig | if_elig);
  assign busy    = is_busy(state_q);

  // ---------------------------------------------------------------------------
  // Arbiter FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
    end else begin
      // valids are single-cycle pulses
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (dm_elig) begin
            state_q     <= DM_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dmWe;
            mem_addr_q  <= dmAddr;
            mem_wdata_q <= dmWdata;
          end else if (if_elig) begin
            state_q    <= IF_BUSY;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= ifAddr;
          end
        end

        DM_BUSY: begin
          if (memAck) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            dm_valid_q <= 1'b1;
            // a store leaves the previous load data in place
            if (!mem_we_q) begin
              dm_rdata_q <= memRdata;
            end
          end
        end

        IF_BUSY: begin
          if (memAck) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            // a flush arriving together with the ack still drops the word
            if (!ifKill) begin
              if_rdata_q <= memRdata;
              if_valid_q <= 1'b1;
            end
          end else if (ifKill) begin
            // keep memReq up: the backend transaction must run to completion
            state_q <= IF_DISCARD;
          end
        end

        IF_DISCARD: begin
          if (memAck) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Acknowledge timeout
  // ---------------------------------------------------------------------------
  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start_i (issue),
    .busy_i  (busy),
    .ack_i   (memAck),
    .err_o   (memErr)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign memReq   = mem_req_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign ifRdata  = if_rdata_q;
  assign ifValid  = if_valid_q;
  assign dmRdata  = dm_rdata_q;
  assign dmValid  = dm_valid_q;
  assign ifStall  = ifReq & ~if_valid_q;
  assign dmStall  = dmReq & ~dm_valid_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios followed by a randomized phase. A transaction-level
//   reference model (one outstanding backend transaction, a kill flag and a
//   stall counter) predicts every registered output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          ifReq, ifKill, dmReq, dmWe, memAck;
  logic [AW-1:0] ifAddr, dmAddr;
  logic [DW-1:0] dmWdata, memRdata;
  logic [DW-1:0] ifRdata, dmRdata, memWdata;
  logic [AW-1:0] memAddr;
  logic          ifValid, ifStall, dmValid, dmStall, memReq, memWe, memErr;
  arbState_t     dbgState;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifKill(ifKill),
    .ifRdata(ifRdata), .ifValid(ifValid), .ifStall(ifStall),
    .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmRdata(dmRdata), .dmValid(dmValid), .dmStall(dmStall),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memAck(memAck), .memRdata(memRdata), .memErr(memErr),
    .dbgState(dbgState)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];   // addresses the model expects on the backend, in order

  bit            m_busy, m_port_dm, m_we, m_killed, m_new;
  bit            m_if_v, m_dm_v, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  int            m_wait;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_port_dm = 0; m_we = 0; m_killed = 0; m_new = 0;
    m_if_v = 0; m_dm_v = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    m_wait = 0;
    exp_q.delete();
  endtask

  // One clock edge of behaviour, from the inputs the bench is driving.
  task automatic model_edge();
    bit n_if_v, n_dm_v;
    n_if_v = 0;
    n_dm_v = 0;
    m_new  = 0;
    if (!m_busy) begin
      if (dmReq && !m_dm_v) begin
        m_busy = 1; m_port_dm = 1; m_we = dmWe; m_addr = dmAddr;
        m_wdata = dmWdata; m_killed = 0; m_wait = 0; m_new = 1;
        exp_q.push_back(dmAddr);
      end else if (ifReq && !ifKill && !m_if_v) begin
        m_busy = 1; m_port_dm = 0; m_we = 0; m_addr = ifAddr;
        m_killed = 0; m_wait = 0; m_new = 1;
        exp_q.push_back(ifAddr);
      end
    end else if (memAck) begin
      m_busy = 0;
      if (m_port_dm) begin
        n_dm_v = 1;
        if (!m_we) m_dm_rdata = memRdata;
      end else if (!m_killed && !ifKill) begin
        n_if_v = 1;
        m_if_rdata = memRdata;
      end
    end else begin
      if (!m_port_dm && ifKill) m_killed = 1;
      if (m_wait < TMO) m_wait++;
      if (TMO > 0 && m_wait >= TMO) m_err = 1;
    end
    m_if_v = n_if_v;
    m_dm_v = n_dm_v;
  endtask

  task automatic compare_all();
    check("memReq", memReq, m_busy);
    if (m_busy) begin
      check("memWe", memWe, m_we);
      check("memAddr", memAddr, m_addr);
      if (m_we) check("memWdata", memWdata, m_wdata);
    end
    if (m_new) check("issue_order", memAddr, exp_q.pop_front());
    check("ifValid", ifValid, m_if_v);
    check("dmValid", dmValid, m_dm_v);
    check("ifRdata", ifRdata, m_if_rdata);
    check("dmRdata", dmRdata, m_dm_rdata);
    check("memErr", memErr, m_err);
    check("idle_state", dbgState == IDLE, !m_busy);
  endtask

  // Called at posedge+1 after inputs are set; returns at the next posedge+1.
  task automatic tick();
    #1;
    check("ifStall", ifStall, ifReq & ~m_if_v);
    check("dmStall", dmStall, dmReq & ~m_dm_v);
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Random drivers (requesters + backend)
  // ---------------------------------------------------------------------------
  bit ack_armed, dm_active, if_active;
  int ack_wait;

  task automatic drive_random();
    memAck = 1'b0;
    if (memReq) begin
      if (!ack_armed) begin
        ack_armed = 1;
        ack_wait  = $urandom_range(0, 2);
      end
      if (ack_wait == 0) begin
        memAck = 1'b1; memRdata = $urandom; ack_armed = 0;
      end else begin
        ack_wait--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      memAck = 1'b1;   // stray ack while idle
      memRdata = $urandom;
    end

    if (dm_active) begin
      if (dmValid) dm_active = 0;   // request stays up through its valid cycle
    end else if ($urandom_range(0, 2) == 0) begin
      dmReq = 1'b1; dmWe = 1'($urandom_range(0, 1));
      dmAddr = $urandom & 32'hFFFF_FFFC; dmWdata = $urandom;
      dm_active = 1;
    end else begin
      dmReq = 1'b0;
    end

    ifKill = 1'b0;
    if (if_active) begin
      if (ifValid) if_active = 0;
      else if ($urandom_range(0, 9) == 0) begin
        ifKill = 1'b1; ifReq = 1'b0; if_active = 0;
      end
    end else if ($urandom_range(0, 1) == 0) begin
      ifReq = 1'b1; ifAddr = $urandom & 32'hFFFF_FFFC; if_active = 1;
      if ($urandom_range(0, 7) == 0) ifKill = 1'b1;
    end else begin
      ifReq = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    ifReq = 0; ifKill = 0; ifAddr = '0;
    dmReq = 0; dmWe = 0; dmAddr = '0; dmWdata = '0;
    memAck = 0; memRdata = '0;
    ack_armed = 0; dm_active = 0; if_active = 0; ack_wait = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_memReq", memReq, 0);
    check("rst_memWe", memWe, 0);
    check("rst_ifValid", ifValid, 0);
    check("rst_dmValid", dmValid, 0);
    check("rst_memErr", memErr, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_memWdata", memWdata, 0);
    check("rst_ifRdata", ifRdata, 0);
    check("rst_dmRdata", dmRdata, 0);
    check("rst_state", dbgState, IDLE);
    reset = 1'b1;

    // dm read 0x40, ack in cycle 1
    dmReq = 1; dmWe = 0; dmAddr = 32'h40;
    tick();                                   // now cycle 1
    check("t1_memReq", memReq, 1);
    check("t1_memAddr", memAddr, 32'h40);
    memAck = 1; memRdata = 32'h1234ABCD;
    tick();                                   // cycle 2
    check("t1_dmValid", dmValid, 1);
    check("t1_dmRdata", dmRdata, 32'h1234ABCD);
    check("t1_idle", dbgState, IDLE);
    memAck = 0;                               // dmReq still held in the valid cycle
    tick();                                   // cycle 3
    check("t1_no_reissue", memReq, 0);
    dmReq = 0;

    // simultaneous fetch 0x100 and write 0x200 -> write first
    ifReq = 1; ifAddr = 32'h100;
    dmReq = 1; dmWe = 1; dmAddr = 32'h200; dmWdata = 32'hCAFE;
    tick();
    check("t2_first_we", memWe, 1);
    check("t2_first_addr", memAddr, 32'h200);
    check("t2_first_wdata", memWdata, 32'hCAFE);
    memAck = 1; memRdata = 32'h9999_9999;
    tick();                                   // dmValid cycle
    check("t2_dmValid", dmValid, 1);
    check("t2_dmRdata_kept", dmRdata, 32'h1234ABCD);
    memAck = 0;
    tick();                                   // fetch issued in the dmValid cycle
    check("t2_fetch_req", memReq, 1);
    check("t2_fetch_addr", memAddr, 32'h100);
    check("t2_fetch_we", memWe, 0);
    dmReq = 0;
    memAck = 1; memRdata = 32'h0C0F_FEE0;
    tick();
    check("t2_ifValid", ifValid, 1);
    check("t2_ifRdata", ifRdata, 32'h0C0F_FEE0);
    memAck = 0;                               // ifReq held through its valid
    tick();
    check("t2_single_txn", memReq, 0);
    ifReq = 0;

    // fetch 0x104, 3-cycle ack, kill in cycle 2
    ifReq = 1; ifAddr = 32'h104;
    tick();                                   // cycle 1
    tick();                                   // cycle 2
    ifKill = 1; ifReq = 0;
    tick();                                   // cycle 3
    check("t3_req_held", memReq, 1);
    ifKill = 0; memAck = 1; memRdata = 32'hDEAD_BEEF;
    tick();                                   // cycle 4
    check("t3_no_ifValid", ifValid, 0);
    check("t3_ifRdata_kept", ifRdata, 32'h0C0F_FEE0);
    check("t3_idle", dbgState, IDLE);
    memAck = 0;
    tick();

    // kill coincident with ack, then a dm read, then a stray ack in idle
    ifReq = 1; ifAddr = 32'h108;
    tick();
    ifReq = 0; ifKill = 1; memAck = 1; memRdata = 32'h7777_7777;
    tick();
    check("t4_no_ifValid", ifValid, 0);
    check("t4_idle", dbgState, IDLE);
    ifKill = 0; memAck = 0;
    dmReq = 1; dmWe = 0; dmAddr = 32'h44;
    tick();
    check("t4_dm_addr", memAddr, 32'h44);
    memAck = 1; memRdata = 32'h55AA_55AA;
    tick();
    check("t4_dmRdata", dmRdata, 32'h55AA_55AA);
    dmReq = 0;
    tick();                                   // stray ack while idle
    check("t4_stray_ack", memReq, 0);
    memAck = 0;
    tick();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      tick();
    end
    ifReq = 0; dmReq = 0; ifKill = 0; memAck = 0;
    for (int n = 0; n < 20; n++) begin
      memAck = memReq;
      memRdata = $urandom;
      tick();
    end
    memAck = 0;
    tick();
    check("drain_idle", dbgState, IDLE);

    // timeout: read that is never acknowledged
    dmReq = 1; dmWe = 0; dmAddr = 32'h80;
    tick();
    check("t5_req", memReq, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t5_memErr", memErr, (k >= 4));
    end
    reset = 1'b0;                             // asynchronous, mid-cycle
    #1;
    check("t5_async_memReq", memReq, 0);
    check("t5_async_memErr", memErr, 0);
    check("t5_async_state", dbgState, IDLE);
    dmReq = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    check("t5_after_reset", memReq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
